seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
- Runtime-programmable serial pattern detector. Generalises the fixed "0110" detector to any pattern of 1..MAX_LEN bits.
- Adds selectable overlapping or non-overlapping match mode, a sample-enable qualifier, and a saturating match counter.
- Sits on a 1-bit serial input stream. Feeds a single-cycle match pulse and count to downstream control or status logic.

Parameters:
- MAX_LEN, 16, longest supported pattern in bits (2..64).
- LEN_W, $clog2(MAX_LEN+1), width of the length field.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- x  input  1  serial data bit.
- x_valid  input  1  x is sampled on this edge only when high.
- cfg_load  input  1  one-cycle pulse; latches the cfg_* inputs.
- cfg_pattern  input  MAX_LEN  pattern in the low cfg_len bits. Bit [cfg_len-1] is the first bit received; bit [0] is the last.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- cnt_clr  input  1  clears match_count.
- z  output  1  match pulse, registered.
- match_count  output  CNT_W  saturating number of matches.
- armed  output  1  high when the history holds at least len valid bits.

Behaviour:
- Reset (rst=1 at an edge):
  - history=0, fill=0, z=0, match_count=0, armed=0.
  - Active config: pattern=0, len=0 (detector disabled), overlap=1.
- cfg_load edge:
  - Active pattern, len and overlap take the cfg_* values.
  - history, fill, z and match_count are cleared.
  - If x_valid is high on the same edge, that sample is discarded (load wins).
- Length rules:
  - len=0 means the detector is disabled; z never asserts.
  - cfg_len > MAX_LEN is clamped to MAX_LEN.
  - Pattern bits at or above len are ignored.
- Sample edge (x_valid=1, no load):
  - history <= {history[MAX_LEN-2:0], x}.
  - fill <= min(fill+1, MAX_LEN).
- Match condition on the same edge:
  - Next history[len-1:0] == pattern[len-1:0], and next fill >= len, and len != 0.
  - On a match, z is set high for exactly one cycle (the cycle following the sampling edge). Otherwise z=0.
- Cycles with x_valid=0: history and fill hold; z=0.
- Non-overlap mode: on a match edge, fill <= 0, so the next match needs len fresh bits.
- Overlap mode: fill is unaffected by a match.
- match_count:
  - Increments on every match edge.
  - Saturates at 2^CNT_W-1.
  - If cnt_clr and a match occur on the same edge, the result is 1.
  - cnt_clr alone gives 0.
- armed = (len != 0) && (fill >= len), registered.
- Mid-operation behaviour:
  - Reset mid-stream discards partial history; no spurious z afterwards.
  - A config change mid-stream only takes effect through cfg_load and always restarts detection.

Decomposition:
- Shared package seq_det_pkg holds:
  - Default MAX_LEN and CNT_W.
  - Typedef cfg_t {pattern, len, overlap}.
  - A function clamp_len().
- One sub-module: seq_sat_counter (CNT_W saturating counter with clear and increment, clear-and-increment yielding 1).
- History register, fill counter and compare stay in the top level.

Test Plan:
- Overlap: pattern 4'b0110, len 4, overlap=1, stream 0,0,1,1,0,1,1,0,0,1,1,0 (x_valid=1) -> z pulses after bits 5, 8 and 12; match_count=3.
- Non-overlap: same stream, overlap=0 -> z pulses after bits 5 and 12 only; match_count=2.
- Gaps, 3-bit pattern: pattern 3'b101, len 3, stream 1,0,1,0,1 with x_valid low for 2 cycles between samples -> overlap: z after bits 3 and 5; non-overlap: z after bit 3 only. z is never high during gaps.
- Long pattern and clamp: MAX_LEN=16, pattern 8'hA5, len 8, stream 0xA5 MSB-first preceded by 3 zeros -> one z after bit 11. Reload with cfg_len=31 -> len reads as 16.
- Saturation and clear: CNT_W=2, pattern 1'b1, len 1, five 1s -> match_count stays at 3. cnt_clr together with a match -> 1.
- Reset and load precedence: rst asserted after 3 of 4 pattern bits, then the 4th bit -> no z. Disabled default (len=0) with any stream -> z=0. cfg_load on the same edge as x_valid -> that bit is dropped and fill=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types, defaults and helpers for the programmable sequence detector.
package seq_det_pkg;

  localparam int unsigned DEF_MAX_LEN = 16;
  localparam int unsigned DEF_CNT_W   = 8;

  // Config payload is sized for the largest supported pattern; unused upper
  // pattern bits are masked off by the active length.
  localparam int unsigned PAT_W  = 64;
  localparam int unsigned LEN_FW = 7;

  typedef struct packed {
    logic [PAT_W-1:0]  pattern;
    logic [LEN_FW-1:0] len;
    logic              overlap;
  } cfg_t;

  // Detector comes out of reset disabled (len=0) with overlap enabled.
  localparam cfg_t CFG_RST = '{pattern: '0, len: '0, overlap: 1'b1};

  // Limit a requested pattern length to the longest the instance supports.
  function automatic logic [LEN_FW-1:0] clamp_len(input int unsigned len,
                                                  input int unsigned max_len);
    logic [LEN_FW-1:0] res;
    if (len > max_len) res = LEN_FW'(max_len);
    else               res = LEN_FW'(len);
    return res;
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating event counter; clear together with increment yields 1.
module seq_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // Count register: clear has priority but still honours a same-edge increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= W'(inc);
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with overlap control,
// sample qualifier and saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  cfg_t               act;
  cfg_t               act_next;
  cfg_t               cfg_new;
  logic [MAX_LEN-1:0] history;
  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   fill_next;
  logic [PAT_W-1:0]   len_mask;
  logic               sample;
  logic               hit;
  logic               match_c;
  logic               armed_next;

  // Next history/fill, match decision and config update for this edge.
  always_comb begin
    sample     = x_valid && !cfg_load;
    hist_shift = {history[MAX_LEN-2:0], x};
    fill_inc   = (32'(fill) >= MAX_LEN) ? fill : fill + LEN_W'(1);
    len_mask   = (PAT_W'(1) << act.len) - PAT_W'(1);
    hit        = (((PAT_W'(hist_shift) ^ act.pattern) & len_mask) == '0);
    match_c    = sample && (act.len != '0) && hit &&
                 (32'(fill_inc) >= 32'(act.len));

    cfg_new.pattern = PAT_W'(cfg_pattern);
    cfg_new.len     = clamp_len(32'(cfg_len), MAX_LEN);
    cfg_new.overlap = cfg_overlap;

    act_next  = act;
    hist_next = history;
    fill_next = fill;
    if (cfg_load) begin
      act_next  = cfg_new;
      hist_next = '0;
      fill_next = '0;
    end else if (sample) begin
      hist_next = hist_shift;
      // Non-overlapping mode restarts the fill so the next match needs fresh bits.
      fill_next = (match_c && !act.overlap) ? '0 : fill_inc;
    end

    armed_next = (act_next.len != '0) && (32'(fill_next) >= 32'(act_next.len));
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      act     <= CFG_RST;
      history <= '0;
      fill    <= '0;
      z       <= 1'b0;
      armed   <= 1'b0;
    end else begin
      act     <= act_next;
      history <= hist_next;
      fill    <= fill_next;
      z       <= match_c;
      armed   <= armed_next;
    end
  end

  seq_sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr | cfg_load),
    .inc   (match_c),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based reference model.
module tb_seq_detector_prog;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned LEN_W   = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               x = 1'b0;
  logic               x_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               cnt_clr = 1'b0;

  logic       z8, armed8, z2, armed2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;
  int stepno = 0;

  // Reference model state
  logic [15:0] mpat;
  int          mlen;
  bit          movl;
  bit          mq[$];
  int          mc8, mc2;
  bit          mz, marm;

  always #5 clk = ~clk;

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z8), .match_count(cnt8), .armed(armed8)
  );

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z2), .match_count(cnt2), .armed(armed2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, stepno, obs, exp);
    end
  endtask

  function automatic int sat_upd(input int c, input bit clr, input bit m, input int maxv);
    int r;
    if (clr)    r = m ? 1 : 0;
    else if (m) r = (c < maxv) ? c + 1 : maxv;
    else        r = c;
    return r;
  endfunction

  // Model: the queue holds the valid bits seen since detection last restarted.
  task automatic model_edge(input bit r, input bit l, input bit xv, input bit xb, input bit c);
    bit m;
    m = 1'b0;
    if (r) begin
      mpat = '0; mlen = 0; movl = 1'b1; mq.delete(); mc8 = 0; mc2 = 0;
    end else if (l) begin
      mpat = cfg_pattern;
      mlen = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
      movl = cfg_overlap;
      mq.delete(); mc8 = 0; mc2 = 0;
    end else begin
      if (xv) begin
        mq.push_back(xb);
        if (mq.size() > MAX_LEN) void'(mq.pop_front());
        if (mlen != 0 && mq.size() >= mlen) begin
          m = 1'b1;
          for (int i = 0; i < mlen; i++)
            if (mq[mq.size() - 1 - i] != mpat[i]) m = 1'b0;
        end
        if (m && !movl) mq.delete();
      end
      mc8 = sat_upd(mc8, c, m, 255);
      mc2 = sat_upd(mc2, c, m, 3);
    end
    mz   = m;
    marm = (mlen != 0) && (mq.size() >= mlen);
  endtask

  task automatic step(input bit r, input bit l, input bit xv, input bit xb, input bit c);
    rst = r; cfg_load = l; x_valid = xv; x = xb; cnt_clr = c;
    @(posedge clk);
    model_edge(r, l, xv, xb, c);
    stepno++;
    #1;
    chk("z", 64'(z8), 64'(mz));
    chk("z_w2", 64'(z2), 64'(mz));
    chk("armed", 64'(armed8), 64'(marm));
    chk("count", 64'(cnt8), 64'(mc8));
    chk("count_w2", 64'(cnt2), 64'(mc2));
  endtask

  task automatic send(input bit b);
    step(1'b0, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [15:0] p, input logic [4:0] len, input bit ovl);
    cfg_pattern = p; cfg_len = len; cfg_overlap = ovl;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send(v[i]);
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_z", 64'(z8), 64'd0);
    chk("rst_count", 64'(cnt8), 64'd0);
    chk("rst_armed", 64'(armed8), 64'd0);

    // Disabled default: no match whatever arrives
    for (int i = 0; i < 10; i++) send(1'($urandom_range(0, 1)));
    chk("disabled_count", 64'(cnt8), 64'd0);

    // Overlapping 0110
    load(16'h0006, 5'd4, 1'b1);
    send_bits(32'b001101100110, 12);
    chk("ovl_count", 64'(cnt8), 64'd3);

    // Non-overlapping 0110
    load(16'h0006, 5'd4, 1'b0);
    send_bits(32'b001101100110, 12);
    chk("novl_count", 64'(cnt8), 64'd2);

    // 101 with gaps, both modes
    for (int mode = 1; mode >= 0; mode--) begin
      load(16'h0005, 5'd3, 1'(mode));
      for (int i = 0; i < 5; i++) begin
        send(1'(i % 2 == 0));
        idle(2);
      end
      chk("gap_count", 64'(cnt8), (mode == 1) ? 64'd2 : 64'd1);
    end

    // 8-bit pattern after leading zeros
    load(16'h00A5, 5'd8, 1'b1);
    send_bits(32'h0A5, 11);
    chk("a5_count", 64'(cnt8), 64'd1);

    // Oversized length clamps to the full history width
    load(16'hBEEF, 5'd31, 1'b1);
    send_bits(32'hBEEF, 16);
    chk("clamp_count", 64'(cnt8), 64'd1);
    chk("clamp_armed", 64'(armed8), 64'd1);

    // Saturation and clear
    load(16'h0001, 5'd1, 1'b1);
    for (int i = 0; i < 5; i++) send(1'b1);
    chk("sat_w2", 64'(cnt2), 64'd3);
    chk("sat_w8", 64'(cnt8), 64'd5);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_inc", 64'(cnt2), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_only", 64'(cnt8), 64'd0);

    // Reset mid-pattern
    load(16'h0006, 5'd4, 1'b1);
    send_bits(32'b011, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0);
    chk("rst_mid_z", 64'(z8), 64'd0);

    // Reload mid-pattern restarts detection
    load(16'h0006, 5'd4, 1'b1);
    send_bits(32'b011, 3);
    load(16'h0006, 5'd4, 1'b1);
    send(1'b0);
    chk("reload_mid_z", 64'(z8), 64'd0);

    // Load wins over a same-edge sample
    cfg_pattern = 16'h0006; cfg_len = 5'd4; cfg_overlap = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("load_drop_armed", 64'(armed8), 64'd0);
    send_bits(32'b110, 3);
    chk("load_drop_count", 64'(cnt8), 64'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 8; k++) begin
      cfg_len = (k == 7) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 6));
      load(16'($urandom), cfg_len, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 150; i++) begin
        step(1'($urandom_range(0, 199) == 0),
             1'($urandom_range(0, 99) == 0),
             1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 19) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
